// File: rtl/clock_step_controller_if.sv
// Handshake bundle between the processor's I/O wait flags and confirms and the
// step controller's clock-enable outputs.
interface clock_step_controller_if;
  logic       enter;
  logic       flagIN;
  logic       flagSend;
  logic       flagReceive;
  logic       send_confirmS;
  logic       send_confirmR;
  logic       step;
  logic       waiting;
  logic [1:0] wait_src;

  modport master (
    output enter, flagIN, flagSend, flagReceive, send_confirmS, send_confirmR,
    input  step, waiting, wait_src
  );

  modport slave (
    input  enter, flagIN, flagSend, flagReceive, send_confirmS, send_confirmR,
    output step, waiting, wait_src
  );
endinterface

// File: rtl/clock_step_controller.sv
// Processor step sequencer: free-running step at DIV_MAX+1 cycles, or one step
// per rising edge of the confirm that matches the highest-priority wait flag.
module clock_step_controller #(
  parameter int CNT_W   = 25,
  parameter int DIV_MAX = 63
) (
  input  logic                    CLOCK,
  input  logic                    reset,
  clock_step_controller_if.slave  bus
);
  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_RELEASE} state_t;

  localparam logic [CNT_W-1:0] DIV_MAX_C = CNT_W'(DIV_MAX);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  logic [1:0]       src_q, src_d;
  logic [2:0]       prev_q;

  // Bit 0 = IN, bit 1 = SEND, bit 2 = RECV; wait_src code is bit index + 1.
  logic [2:0] flag, conf, rise;
  logic       sel_flag, sel_conf, sel_rise;

  assign flag = {bus.flagReceive, bus.flagSend, bus.flagIN};
  assign conf = {bus.send_confirmR, bus.send_confirmS, bus.enter};
  assign rise = conf & ~prev_q;

  always_comb begin
    sel_flag = 1'b0;
    sel_conf = 1'b0;
    sel_rise = 1'b0;
    case (src_q)
      2'd1: begin sel_flag = flag[0]; sel_conf = conf[0]; sel_rise = rise[0]; end
      2'd2: begin sel_flag = flag[1]; sel_conf = conf[1]; sel_rise = rise[1]; end
      2'd3: begin sel_flag = flag[2]; sel_conf = conf[2]; sel_rise = rise[2]; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    src_d   = src_q;
    case (state_q)
      ST_RUN: begin
        if (|flag) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
          src_d   = flag[0] ? 2'd1 : (flag[1] ? 2'd2 : 2'd3);
        end else if (cnt_q == DIV_MAX_C) begin
          cnt_d  = '0;
          step_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        // A dropped flag wins over a confirm edge in the same cycle.
        if (!sel_flag) begin
          state_d = ST_RUN;
          src_d   = 2'd0;
          cnt_d   = '0;
        end else if (sel_rise) begin
          state_d = ST_RELEASE;
          step_d  = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!sel_conf) begin
          state_d = ST_RUN;
          src_d   = 2'd0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_RUN;
        src_d   = 2'd0;
        cnt_d   = '0;
      end
    endcase
  end

  // History resets high so a confirm held through reset is not seen as a rise.
  always_ff @(posedge CLOCK) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      src_q   <= 2'd0;
      prev_q  <= 3'b111;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      src_q   <= src_d;
      prev_q  <= conf;
    end
  end

  assign bus.step     = step_q;
  assign bus.waiting  = (state_q == ST_WAIT);
  assign bus.wait_src = src_q;
endmodule

// File: tb/tb_clock_step_controller.sv
// Scoreboarded random/directed bench for clock_step_controller with a
// behavioural model of the stepping rules.
module tb_clock_step_controller;
  localparam int DIV = 3;

  logic CLOCK = 1'b0;
  logic reset = 1'b1;
  clock_step_controller_if bus();

  clock_step_controller #(.CNT_W(25), .DIV_MAX(DIV)) dut (
    .CLOCK (CLOCK),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct packed {
    logic       step;
    logic       waiting;
    logic [1:0] src;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;
  int   cycle  = 0;

  // Reference model: mode 0=running, 1=waiting on src, 2=waiting for release.
  initial begin : model
    int  mode, src, run_edges;
    bit  prev[1:3], cf[1:3], fl[1:3], rs[1:3];
    exp_t e;
    mode = 0; src = 0; run_edges = 0;
    for (int i = 1; i <= 3; i++) prev[i] = 1'b1;
    forever begin
      @(posedge CLOCK);
      cycle++;
      cf[1] = bus.enter;  cf[2] = bus.send_confirmS; cf[3] = bus.send_confirmR;
      fl[1] = bus.flagIN; fl[2] = bus.flagSend;      fl[3] = bus.flagReceive;
      e = '0;
      if (reset) begin
        mode = 0; src = 0; run_edges = 0;
        for (int i = 1; i <= 3; i++) prev[i] = 1'b1;
      end else begin
        for (int i = 1; i <= 3; i++) begin
          rs[i]   = cf[i] & ~prev[i];
          prev[i] = cf[i];
        end
        if (mode == 0) begin
          if (fl[1] | fl[2] | fl[3]) begin
            src = fl[1] ? 1 : (fl[2] ? 2 : 3);
            mode = 1; run_edges = 0;
          end else begin
            run_edges++;
            e.step = ((run_edges % (DIV + 1)) == 0);
          end
        end else if (mode == 1) begin
          if (!fl[src]) begin
            mode = 0; src = 0; run_edges = 0;
          end else if (rs[src]) begin
            e.step = 1'b1; mode = 2;
          end
        end else begin
          if (!cf[src]) begin
            mode = 0; src = 0; run_edges = 0;
          end
        end
      end
      e.waiting = (mode == 1);
      e.src     = 2'(src);
      exp_q.push_back(e);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLOCK);
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL scoreboard_empty cycle %0d: got no expected entry, required one", cycle);
      end else begin
        e = exp_q.pop_front();
        if (bus.step !== e.step) begin
          failed++;
          $display("FAIL step cycle %0d: got %b required %b", cycle, bus.step, e.step);
        end
        tests++;
        if (bus.waiting !== e.waiting) begin
          failed++;
          $display("FAIL waiting cycle %0d: got %b required %b", cycle, bus.waiting, e.waiting);
        end
        tests++;
        if (bus.wait_src !== e.src) begin
          failed++;
          $display("FAIL wait_src cycle %0d: got %0d required %0d", cycle, bus.wait_src, e.src);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic clear_inputs();
    bus.enter = 0; bus.flagIN = 0; bus.flagSend = 0; bus.flagReceive = 0;
    bus.send_confirmS = 0; bus.send_confirmR = 0;
  endtask

  initial begin : driver
    clear_inputs();
    bus.send_confirmR = 1;
    reset = 1; cyc(3);
    reset = 0;
    $display("[TB] phase free-run");
    cyc(20);
    $display("[TB] phase IN+SEND priority, long enter hold");
    bus.flagIN = 1; bus.flagSend = 1; cyc(3);
    bus.send_confirmS = 1; cyc(1); bus.send_confirmS = 0; cyc(2);
    bus.send_confirmS = 1; cyc(1); bus.send_confirmS = 0; cyc(2);
    bus.enter = 1; cyc(50);
    bus.flagIN = 0; bus.enter = 0; cyc(3);
    bus.send_confirmS = 1; cyc(3); bus.send_confirmS = 0; bus.flagSend = 0; cyc(6);
    $display("[TB] phase RECV confirm held through reset");
    bus.send_confirmR = 1; bus.flagReceive = 1; reset = 1; cyc(2);
    reset = 0; cyc(5);
    bus.send_confirmR = 0; cyc(2); bus.send_confirmR = 1; cyc(4);
    bus.send_confirmR = 0; bus.flagReceive = 0; cyc(6);
    $display("[TB] phase abort beats confirm");
    bus.flagSend = 1; cyc(3);
    bus.flagSend = 0; bus.send_confirmS = 1; cyc(1); bus.send_confirmS = 0; cyc(9);
    $display("[TB] phase reset in WAIT");
    bus.flagIN = 1; cyc(4); reset = 1; bus.flagIN = 0; cyc(1); reset = 0; cyc(10);
    $display("[TB] phase random");
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 15) == 0) bus.flagIN        = ~bus.flagIN;
      if ($urandom_range(0, 15) == 0) bus.flagSend      = ~bus.flagSend;
      if ($urandom_range(0, 15) == 0) bus.flagReceive   = ~bus.flagReceive;
      if ($urandom_range(0, 5)  == 0) bus.enter         = ~bus.enter;
      if ($urandom_range(0, 5)  == 0) bus.send_confirmS = ~bus.send_confirmS;
      if ($urandom_range(0, 5)  == 0) bus.send_confirmR = ~bus.send_confirmR;
      reset = ($urandom_range(0, 199) == 0);
      cyc(1);
    end
    reset = 0; clear_inputs(); cyc(12);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/clock_step_controller.md
# clock_step_controller

Sequences the processor's instruction stepping. It issues a one-cycle `step` enable either at a programmable free-running rate or, while the processor signals an IN, SEND or RECEIVE instruction, only after the matching external confirm (enter button, send confirm, receive confirm) shows a rising edge. The block sits between the I/O handshake inputs and the processor's clock-enable. It arbitrates between simultaneous wait requests with fixed priority and guarantees exactly one step per confirm press.

## Interface
- `CNT_W`, default 25: divide counter width.
- `DIV_MAX`, default 63: free-run terminal count; one step every DIV_MAX+1 cycles. Must satisfy 1 ≤ DIV_MAX < 2^CNT_W.

- `CLOCK` in 1: sole clock; all logic on posedge.
- `reset` in 1: synchronous, active-high reset.
- `enter` in 1: IN-confirm (button), already synchronised.
- `flagIN` in 1: processor waiting for input.
- `flagSend` in 1: processor waiting for send confirm.
- `flagReceive` in 1: processor waiting for receive confirm.
- `send_confirmS` in 1: send confirm.
- `send_confirmR` in 1: receive confirm.
- `step` out 1: registered one-cycle processor advance enable.
- `waiting` out 1: high in WAIT states.
- `wait_src` out 2: 0 none, 1 IN, 2 SEND, 3 RECV; valid in WAIT and RELEASE, 0 in RUN.

## Operation
- States: RUN, WAIT, RELEASE. `wait_src` holds the latched source in WAIT and RELEASE.
- Reset: state RUN, counter 0, `step`=0, `waiting`=0, `wait_src`=0. The edge-detect history registers for all three confirms reset to 1, so a confirm held high through reset never yields a step.
- Each cycle, every confirm's previous value is registered. `rise_x = confirm_x & ~prev_x`.
- RUN:
  - If any flag is high, go to WAIT. Latch source by priority IN > SEND > RECV, set counter to 0, `step`=0. Flags take priority over the count.
  - Otherwise, if counter == DIV_MAX: counter←0, `step`←1.
  - Otherwise: counter←counter+1, `step`←0.
- WAIT (`waiting`=1), evaluated against the latched source's flag and confirm only:
  - If the latched flag is low: abort to RUN with counter 0 and no step. Abort wins over a simultaneous rising edge.
  - Else if the latched confirm rises: `step`←1, go to RELEASE.
  - Other flags and confirms are ignored. A lower-priority flag still high on return to RUN is serviced next.
- RELEASE (`waiting`=0, `step`=0): stay until the latched confirm is low, then go to RUN with counter 0. A long button hold therefore yields exactly one step.
- Counter arithmetic is unsigned, CNT_W bits. It never exceeds DIV_MAX. It is only modified in RUN, and held at 0 elsewhere.

## Timing
- All outputs are registered. `step` is never high for two consecutive cycles.
- Free-run: cycle 1 is the first posedge with `reset` low. `step` is high on cycles DIV_MAX+1, 2(DIV_MAX+1), and so on.
- A flag high at posedge n gives `waiting`=1 from cycle n+1. No step is issued on that edge, even if the count reached DIV_MAX.
- A confirm first seen high at posedge n, while in WAIT with its prev=0, gives `step`=1 for cycle n+1. Because of the edge register, a confirm already high on entry to WAIT must drop and rise again.
- After RELEASE exits at posedge m, the next free-run step comes DIV_MAX+1 cycles after m, unless a flag is pending.
- Reset asserted mid-WAIT or mid-RELEASE: next cycle is RUN with all outputs 0. Any pending handshake is dropped.

## Test plan
- DIV_MAX=3, no flags, 20 cycles after reset -> `step` high exactly on cycles 4, 8, 12, 16, 20; `waiting`=0 throughout.
- flagIN and flagSend both high at cycle 2 -> `wait_src`=1, `waiting`=1. `send_confirmS` pulses are ignored. An `enter` rise at cycle 10 gives `step`=1 at cycle 11, then RELEASE.
- In RELEASE with `enter` held high for 50 cycles -> no further step. `enter` low at cycle 61 gives RUN at 62. With flagSend still high, WAIT is entered with `wait_src`=2.
- `send_confirmR` high through reset and flagReceive high -> no step until `send_confirmR` goes 0 and then 1. Exactly one `step` follows.
- flagSend drops in WAIT in the same cycle `send_confirmS` rises -> no step. State RUN, counter restarts at 0.
- Reset asserted in WAIT at cycle 7 -> cycle 8 shows `step`=0, `waiting`=0, `wait_src`=0. Free-run resumes with the first step DIV_MAX+1 cycles after reset deasserts.
